// File: rtl/branch_unit.sv
// Branch unit: resolves JMP/JZ/JNZ (and CALL/RET when BRANCH_STACK_EN is defined),
// drives a registered jump to the program counter and squashes wrong-path fetches.
module branch_unit #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned SHADOW_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              zero_flag,
    output logic              jmp,
    output logic [ADDR_W-1:0] jmp_addr,
    output logic              flush,
    output logic              stack_err
);

    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JNZ = 4'hC;
    localparam int unsigned CNT_W = (SHADOW_CYC > 0) ? $clog2(SHADOW_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, SHADOW} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              take;
    logic [ADDR_W-1:0] dest;

`ifdef BRANCH_STACK_EN
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam int unsigned SP_W   = $clog2(STACK_DEPTH) + 1;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d, sp_top;
    logic              err_q, err_d;
    logic              push;
    logic              full, empty;

    assign sp_top    = sp_q - SP_W'(1);
    assign full      = (sp_q == SP_W'(STACK_DEPTH));
    assign empty     = (sp_q == '0);
    assign stack_err = err_q;
`else
    localparam int unsigned unused_depth = STACK_DEPTH;
    logic unused_pc;
    assign unused_pc = ^pc_in;
    assign stack_err = 1'b0;
`endif

    // Decode: only an IDLE cycle may evaluate a jump or touch the stack
    always_comb begin
        take = 1'b0;
        dest = target;
`ifdef BRANCH_STACK_EN
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
`endif
        if (instr_valid && state_q == IDLE) begin
            case (opcode)
                OP_JMP: take = 1'b1;
                OP_JZ:  take = zero_flag;
                OP_JNZ: take = !zero_flag;
`ifdef BRANCH_STACK_EN
                OP_CALL: begin
                    take = 1'b1;
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        take = 1'b1;
                        dest = stack_q[sp_top[SP_W-2:0]];
                        sp_d = sp_top;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = ISSUE;
                    addr_d  = dest;
                end
            end
            ISSUE: begin
                if (SHADOW_CYC > 0) begin
                    state_d = SHADOW;
                    cnt_d   = CNT_W'(SHADOW_CYC);
                end else begin
                    state_d = IDLE;
                end
            end
            SHADOW: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

`ifdef BRANCH_STACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return addresses wrap modulo 2^ADDR_W; entries need no reset since sp_q gates them
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_q[sp_q[SP_W-2:0]] <= pc_in + ADDR_W'(1);
        end
    end
`endif

    assign jmp      = (state_q == ISSUE);
    assign flush    = (state_q != IDLE);
    assign jmp_addr = addr_q;

endmodule

// File: doc/branch_unit.md
# branch_unit

- Generates the jump controls for the program counter: `jmp` and the 12-bit `jmp_addr`.
- Sits beside the instruction decoder. Each cycle it takes the decoded opcode, its operand target and the address of the current instruction.
- Resolves unconditional and zero-flag-conditional jumps, plus CALL/RET through a small return-address stack.
- Asserts a squash signal so the wrong-path instructions fetched after a taken jump are discarded.

## Interface

Parameters:
- `ADDR_W`, 12, instruction address width (matches the program counter).
- `STACK_DEPTH`, 4, return-address stack entries (power of two, ≥ 2).
- `SHADOW_CYC`, 1, extra squash cycles after the jump cycle (≥ 0).

Ports:
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `instr_valid` input 1: `opcode`, `target` and `pc_in` are valid this cycle.
- `opcode` input 4: decoded opcode.
- `target` input ADDR_W: jump/call destination operand.
- `pc_in` input ADDR_W: address of the instruction currently presented.
- `zero_flag` input 1: ALU zero flag, valid with `instr_valid`.
- `jmp` output 1: registered jump enable to the program counter.
- `jmp_addr` output ADDR_W: registered jump destination.
- `flush` output 1: squash the instruction presented this cycle.
- `stack_err` output 1: sticky stack overflow/underflow flag.

## Operation

- Opcodes:
  - JMP = 4'hA
  - JZ = 4'hB (taken if `zero_flag` = 1)
  - JNZ = 4'hC (taken if `zero_flag` = 0)
  - CALL = 4'hD
  - RET = 4'hE
  - Any other opcode: no action.
- FSM states: IDLE, ISSUE, SHADOW.
- **IDLE**
  - If `instr_valid` and the jump is taken: `jmp_addr` ← destination, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - `jmp` = 1 and `flush` = 1 for exactly one cycle.
  - Go to SHADOW if `SHADOW_CYC` > 0, else back to IDLE.
- **SHADOW**
  - `flush` = 1 for `SHADOW_CYC` cycles, counted by an internal down-counter, then IDLE.
- In ISSUE and SHADOW, `instr_valid` is ignored: no jumps are evaluated and the stack is not touched.
- **CALL**
  - Push `pc_in + 1`, computed modulo 2^ADDR_W, so 12'hFFF yields 12'h000.
  - Destination = `target`.
- **RET**
  - Pop the top entry; destination = popped value.
- **Overflow**: CALL while the stack holds `STACK_DEPTH` entries.
  - No push; `stack_err` ← 1.
  - Jump is still taken.
- **Underflow**: RET while the stack is empty.
  - `stack_err` ← 1.
  - No jump; behaves as a non-jump opcode and the FSM stays in IDLE.
- `stack_err` clears only on `rst`.

## Timing

- Reset values:
  - `jmp` = 0, `jmp_addr` = 0, `flush` = 0, `stack_err` = 0.
  - Stack empty; FSM in IDLE; shadow counter 0.
- Latency for a taken jump presented in cycle n:
  - `jmp` and `jmp_addr` are high/valid in cycle n+1.
  - The program counter loads `jmp_addr` at the end of cycle n+1.
- `flush` is high in cycles n+1 through n+1+`SHADOW_CYC`; its total high time is `SHADOW_CYC`+1 cycles.
- No back-to-back jumps: the next jump is evaluated no earlier than cycle n+2+`SHADOW_CYC`.
- `jmp_addr` holds its last value when `jmp` = 0.
- Reset mid-operation (in ISSUE or SHADOW):
  - Next cycle the FSM is in IDLE with `jmp` = `flush` = 0.
  - Stack is cleared and `stack_err` = 0.
- Push/pop never happen in the same cycle, since only one opcode is presented per cycle.

## Configuration

- Macro `BRANCH_STACK_EN`.
- Defined:
  - CALL/RET and the return-address stack are implemented as described.
- Undefined:
  - No stack storage is built.
  - CALL and RET are treated as non-jump opcodes.
  - `stack_err` is tied to 0.
  - JMP/JZ/JNZ behaviour is unchanged.

## Test plan

- **Reset, then JMP.** `rst` for 2 cycles, then JMP with `target` = 12'h123 in cycle n.
  - All outputs 0 after reset.
  - `jmp` = 1 and `jmp_addr` = 12'h123 in n+1 only.
  - `flush` high in n+1..n+2 (`SHADOW_CYC` = 1).
- **Conditional jumps.**
  - JZ with `zero_flag` = 0 → no `jmp`, no `flush`.
  - JNZ with `zero_flag` = 0 and `target` = 12'h040 → `jmp_addr` = 12'h040.
- **Shadow squash.** `instr_valid` JMP presented in the ISSUE and SHADOW cycles right after a taken jump → ignored; no second `jmp`.
- **Nested CALL/RET.**
  - CALL at `pc_in` 12'h010 → 12'h200, then CALL at 12'h201 → 12'h300.
  - First RET → `jmp_addr` = 12'h202; second RET → 12'h011.
  - Also cover CALL at `pc_in` 12'hFFF: the following RET → `jmp_addr` = 12'h000.
- **Stack error.**
  - Five CALLs with `STACK_DEPTH` = 4 → fifth still jumps and `stack_err` = 1.
  - After `rst`, RET on the empty stack → no `jmp` and `stack_err` = 1.
  - `stack_err` stays 1 until the next `rst`.
- **Reset mid-jump.** Assert `rst` in the ISSUE cycle → next cycle `jmp` = 0, `flush` = 0, stack empty; a following RET underflows.
